dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data SRAM between two requesters: the core MEM-stage load/store port (CPU) and the interrupt context save/restore engine (CTX).
- Arbitrates per cycle and drives the SRAM's active-low chip/write enables, address, byte mask and write data.
- Routes 1-cycle-latency read data back to whichever requester issued the read.
- Guarantees CTX forward progress with a starvation counter, and tells the core pipeline when it must stall.

Parameters:
- ADDR_W, 10, SRAM word-address width.
- DATA_W, 32, data width; the mask is DATA_W/8 bits.
- STARVE_MAX, 4, consecutive denied CTX request cycles before CTX takes priority; legal range 1..15.

Ports:
- clk  in  1  single clock; SRAM and all state on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  CPU access request, held until granted.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_W  word address.
- cpu_mask_i  in  DATA_W/8  byte enables for stores.
- cpu_wdata_i  in  DATA_W  store data, already lane-aligned.
- cpu_gnt_o  out  1  request accepted this cycle; when req & ~gnt, the core stalls.
- cpu_rvalid_o  out  1  load data valid on cpu_rdata_o.
- cpu_rdata_o  out  DATA_W  load data.
- ctx_req_i, ctx_we_i, ctx_addr_i, ctx_mask_i, ctx_wdata_i, ctx_gnt_o, ctx_rvalid_o, ctx_rdata_o: same widths and meanings, for CTX.
- mem_ceb_o  out  1  SRAM chip enable, active low.
- mem_web_o  out  1  SRAM write enable, active low (0 = write).
- mem_addr_o  out  ADDR_W  SRAM address.
- mem_mask_o  out  DATA_W/8  SRAM byte mask.
- mem_wdata_o  out  DATA_W  SRAM write data.
- mem_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read.

Behaviour:
- Grant logic is combinational in the request cycle; the SRAM samples mem_* on the next rising edge.
- At most one grant per cycle. The winner's request fields are muxed onto mem_*.
  - mem_ceb_o = ~(cpu_gnt_o | ctx_gnt_o).
  - mem_web_o = ~winner_we.
  - With no grant: mem_web_o=1, mem_addr_o/mem_mask_o/mem_wdata_o = 0.
- Priority FSM, two states:
  - CPU_PRI (reset state): CPU wins any conflict.
  - CTX_PRI: CTX wins any conflict.
  - With a single requester, that requester is always granted.
- Starvation counter starve_cnt (4 bits):
  - In CPU_PRI, increments on each cycle with ctx_req_i & ~ctx_gnt_o.
  - Clears to 0 on a CTX grant or when ctx_req_i=0.
  - Saturates at STARVE_MAX.
- Transitions:
  - CPU_PRI -> CTX_PRI at the edge where starve_cnt reaches STARVE_MAX (i.e. after STARVE_MAX denied cycles).
  - CTX_PRI -> CPU_PRI on the edge after any CTX grant, or when ctx_req_i deasserts.
  - Result: CTX gets exactly one priority slot per starvation episode.
- Read return:
  - Registered rd_owner {NONE, CPU, CTX} is set at the edge of a granted read, and NONE otherwise (a write grant or no grant).
  - cpu_rvalid_o = (rd_owner==CPU); ctx_rvalid_o = (rd_owner==CTX). Each is a one-cycle pulse, exactly 1 cycle after the grant cycle.
  - cpu_rdata_o and ctx_rdata_o both pass mem_rdata_i through; they are meaningful only while their rvalid is high.
- Back-to-back reads by the same or alternating requesters are allowed every cycle; the pipelined rd_owner keeps routing correct.
- Writes produce no rvalid.
- Reset (asynchronous, immediate):
  - state=CPU_PRI, starve_cnt=0, rd_owner=NONE.
  - All gnt and rvalid outputs are 0, and mem_ceb_o=1, while resetn=0.
  - A read granted in the cycle that reset asserts never produces rvalid.
- Request fields are don't-care while the corresponding req is 0.

Decomposition:
- Shared package/defines: rd_owner encoding (OWNER_NONE=2'd0, OWNER_CPU=2'd1, OWNER_CTX=2'd2) and FSM state encoding (ARB_CPU_PRI, ARB_CTX_PRI).
- One natural sub-module: dmem_req_mux, a purely combinational selection of winner fields onto mem_*. Everything else stays in the top module.

Test Plan:
- CPU only: cpu load at addr 0x010, SRAM word 0xDEADBEEF -> cpu_gnt_o=1 same cycle, mem_ceb_o=0, mem_web_o=1; next cycle cpu_rvalid_o=1 and cpu_rdata_o=0xDEADBEEF; ctx_rvalid_o stays 0.
- CTX only: ctx store to 0x3FF, mask 4'b1100, data 0x12340000 -> ctx_gnt_o=1, mem_web_o=0, mem_mask_o=4'b1100; a later CTX read of 0x3FF returns upper half 0x1234.
- Conflict with starvation: both requesting continuously, STARVE_MAX=4 -> CPU granted cycles 0-3, CTX granted cycle 4, CPU granted cycle 5 onward, with starve_cnt cleared.
- Interleaved reads: CPU read 0x001 at cycle n, CTX read 0x002 at cycle n+1 -> cpu_rvalid_o at n+1, ctx_rvalid_o at n+2, each carrying its own word.
- Reset mid-operation: resetn low in the cycle after a CPU read grant -> cpu_rvalid_o=0 immediately; after release, state=CPU_PRI and the first conflict goes to CPU.
- Idle: no requests -> mem_ceb_o=1, both gnt=0, both rvalid=0, starve_cnt=0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-SRAM port arbiter:
// read-return owner and priority FSM encodings.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_CTX  = 2'd2
  } rd_owner_e;

  typedef enum logic {
    ARB_CPU_PRI = 1'b0,
    ARB_CTX_PRI = 1'b1
  } arb_state_e;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/dmem_req_mux.sv
// Combinational steering of the granted requester onto the SRAM pins.
// In: cpu/ctx select + request fields. Out: mem_ceb/web/addr/mask/wdata.
module dmem_req_mux
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              cpu_sel_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [MASK_W-1:0] cpu_mask_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              ctx_sel_i,
  input  logic              ctx_we_i,
  input  logic [ADDR_W-1:0] ctx_addr_i,
  input  logic [MASK_W-1:0] ctx_mask_i,
  input  logic [DATA_W-1:0] ctx_wdata_i,
  output logic              mem_ceb_o,
  output logic              mem_web_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [MASK_W-1:0] mem_mask_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  always_comb begin
    mem_ceb_o   = 1'b1;
    mem_web_o   = 1'b1;
    mem_addr_o  = '0;
    mem_mask_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      cpu_sel_i: begin
        mem_ceb_o   = 1'b0;
        mem_web_o   = ~cpu_we_i;
        mem_addr_o  = cpu_addr_i;
        mem_mask_o  = cpu_mask_i;
        mem_wdata_o = cpu_wdata_i;
      end
      ctx_sel_i: begin
        mem_ceb_o   = 1'b0;
        mem_web_o   = ~ctx_we_i;
        mem_addr_o  = ctx_addr_i;
        mem_mask_o  = ctx_mask_i;
        mem_wdata_o = ctx_wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data SRAM between CPU and CTX engine.
// Ports: cpu_*/ctx_* request+return, mem_* SRAM pins, clk, resetn.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W/8-1:0]   cpu_mask_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  input  logic                  ctx_req_i,
  input  logic                  ctx_we_i,
  input  logic [ADDR_W-1:0]     ctx_addr_i,
  input  logic [DATA_W/8-1:0]   ctx_mask_i,
  input  logic [DATA_W-1:0]     ctx_wdata_i,
  output logic                  ctx_gnt_o,
  output logic                  ctx_rvalid_o,
  output logic [DATA_W-1:0]     ctx_rdata_o,
  output logic                  mem_ceb_o,
  output logic                  mem_web_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_mask_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam logic [STARVE_W-1:0] STARVE_LIM =
    STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  rd_owner_e           owner_q, owner_d;

  logic cpu_gnt, ctx_gnt;

  // Grants are held low while reset is asserted so the SRAM
  // never sees a chip enable during reset.
  assign cpu_gnt = resetn & cpu_req_i &
                   (~ctx_req_i | (state_q == ARB_CPU_PRI));
  assign ctx_gnt = resetn & ctx_req_i &
                   (~cpu_req_i | (state_q == ARB_CTX_PRI));

  assign cpu_gnt_o = cpu_gnt;
  assign ctx_gnt_o = ctx_gnt;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    owner_d  = OWNER_NONE;

    if (ctx_gnt || !ctx_req_i) begin
      starve_d = '0;
    end else if (state_q == ARB_CPU_PRI &&
                 starve_q < STARVE_LIM) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    // Priority flips the same edge the count hits the limit,
    // and drops back after the one CTX slot is used.
    unique case (state_q)
      ARB_CPU_PRI:
        if (starve_d == STARVE_LIM) state_d = ARB_CTX_PRI;
      ARB_CTX_PRI:
        if (ctx_gnt || !ctx_req_i) state_d = ARB_CPU_PRI;
    endcase

    unique case (1'b1)
      cpu_gnt & ~cpu_we_i: owner_d = OWNER_CPU;
      ctx_gnt & ~ctx_we_i: owner_d = OWNER_CTX;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB_CPU_PRI;
      starve_q <= '0;
      owner_q  <= OWNER_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign cpu_rvalid_o = (owner_q == OWNER_CPU);
  assign ctx_rvalid_o = (owner_q == OWNER_CTX);
  assign cpu_rdata_o  = mem_rdata_i;
  assign ctx_rdata_o  = mem_rdata_i;

  dmem_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .cpu_sel_i   (cpu_gnt),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_mask_i  (cpu_mask_i),
    .cpu_wdata_i (cpu_wdata_i),
    .ctx_sel_i   (ctx_gnt),
    .ctx_we_i    (ctx_we_i),
    .ctx_addr_i  (ctx_addr_i),
    .ctx_mask_i  (ctx_mask_i),
    .ctx_wdata_i (ctx_wdata_i),
    .mem_ceb_o   (mem_ceb_o),
    .mem_web_o   (mem_web_o),
    .mem_addr_o  (mem_addr_o),
    .mem_mask_o  (mem_mask_o),
    .mem_wdata_o (mem_wdata_o)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural SRAM.
// Vector table for single-cycle behaviour, sequences for corners.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req, cpu_we, ctx_req, ctx_we;
  logic [9:0]  cpu_addr, ctx_addr;
  logic [3:0]  cpu_mask, ctx_mask;
  logic [31:0] cpu_wdata, ctx_wdata;
  logic        cpu_gnt, cpu_rvalid, ctx_gnt, ctx_rvalid;
  logic [31:0] cpu_rdata, ctx_rdata;
  logic        mem_ceb, mem_web;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_mask_i(cpu_mask),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt),
    .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .ctx_req_i(ctx_req), .ctx_we_i(ctx_we),
    .ctx_addr_i(ctx_addr), .ctx_mask_i(ctx_mask),
    .ctx_wdata_i(ctx_wdata), .ctx_gnt_o(ctx_gnt),
    .ctx_rvalid_o(ctx_rvalid), .ctx_rdata_o(ctx_rdata),
    .mem_ceb_o(mem_ceb), .mem_web_o(mem_web),
    .mem_addr_o(mem_addr), .mem_mask_o(mem_mask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // SRAM model: unwritten words hold a fixed address pattern.
  bit [31:0] arr [1024];
  bit        wr  [1024];

  function automatic logic [31:0] init_word(logic [9:0] a);
    if (a == 10'h010) return 32'hDEADBEEF;
    return 32'hA5A50000 | {22'd0, a};
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur;
    if (!mem_ceb) begin
      cur = wr[mem_addr] ? arr[mem_addr] : init_word(mem_addr);
      if (!mem_web) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
        arr[mem_addr] <= cur;
        wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= cur;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    logic cr, logic cw, logic [9:0] ca, logic [3:0] cm, logic [31:0] cd,
    logic xr, logic xw, logic [9:0] xa, logic [3:0] xm, logic [31:0] xd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca;
    cpu_mask = cm; cpu_wdata = cd;
    ctx_req = xr; ctx_we = xw; ctx_addr = xa;
    ctx_mask = xm; ctx_wdata = xd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic cr; logic cw; logic [9:0] ca; logic [3:0] cm; logic [31:0] cd;
    logic xr; logic xw; logic [9:0] xa; logic [3:0] xm; logic [31:0] xd;
    logic gc; logic gx; logic ceb; logic web;
    logic [9:0] addr; logic [3:0] mask; logic [31:0] wd;
    logic rvc; logic rvx; logic [31:0] rd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // CPU load of 0x010, then it returns DEADBEEF
    tbl[0]  = '{1,0,10'h010,4'hF,0, 0,0,0,0,0,
                1,0,0,1,10'h010,4'hF,0, 0,0,0};
    tbl[1]  = '{0,0,0,0,0, 0,0,0,0,0,
                0,0,1,1,0,0,0, 1,0,32'hDEADBEEF};
    // CTX half-word store then read back
    tbl[2]  = '{0,0,0,0,0, 1,1,10'h3FF,4'hC,32'h12340000,
                0,1,0,0,10'h3FF,4'hC,32'h12340000, 0,0,0};
    tbl[3]  = '{0,0,0,0,0, 1,0,10'h3FF,4'hF,0,
                0,1,0,1,10'h3FF,4'hF,0, 0,0,0};
    tbl[4]  = '{0,0,0,0,0, 0,0,0,0,0,
                0,0,1,1,0,0,0, 0,1,32'h123403FF};
    // Interleaved CPU then CTX reads
    tbl[5]  = '{1,0,10'h001,4'hF,0, 0,0,0,0,0,
                1,0,0,1,10'h001,4'hF,0, 0,0,0};
    tbl[6]  = '{0,0,0,0,0, 1,0,10'h002,4'hF,0,
                0,1,0,1,10'h002,4'hF,0, 1,0,32'hA5A50001};
    tbl[7]  = '{0,0,0,0,0, 0,0,0,0,0,
                0,0,1,1,0,0,0, 0,1,32'hA5A50002};
    // Back-to-back CPU reads, a write (no rvalid), read-back
    tbl[8]  = '{1,0,10'h005,4'hF,0, 0,0,0,0,0,
                1,0,0,1,10'h005,4'hF,0, 0,0,0};
    tbl[9]  = '{1,0,10'h006,4'hF,0, 0,0,0,0,0,
                1,0,0,1,10'h006,4'hF,0, 1,0,32'hA5A50005};
    tbl[10] = '{1,1,10'h005,4'h3,32'h0000BEEF, 0,0,0,0,0,
                1,0,0,0,10'h005,4'h3,32'h0000BEEF, 1,0,32'hA5A50006};
    tbl[11] = '{1,0,10'h005,4'hF,0, 0,0,0,0,0,
                1,0,0,1,10'h005,4'hF,0, 0,0,0};
    tbl[12] = '{0,0,0,0,0, 0,0,0,0,0,
                0,0,1,1,0,0,0, 1,0,32'hA5A5BEEF};
    tbl[13] = '{0,0,0,0,0, 0,0,0,0,0,
                0,0,1,1,0,0,0, 0,0,0};

    // Reset: requests present but nothing granted
    drive(1, 0, 10'h010, 4'hF, 0, 1, 0, 10'h020, 4'hF, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_ctx_gnt", 32'(ctx_gnt), 0);
    chk("rst_ceb", 32'(mem_ceb), 1);
    chk("rst_rvalid", 32'({cpu_rvalid, ctx_rvalid}), 0);
    @(posedge clk); #1;
    idle();
    resetn = 1'b1;

    // Idle after reset
    @(negedge clk);
    chk("idle_ceb", 32'(mem_ceb), 1);
    chk("idle_gnt", 32'({cpu_gnt, ctx_gnt}), 0);
    chk("idle_rvalid", 32'({cpu_rvalid, ctx_rvalid}), 0);
    chk("idle_starve", 32'(dut.starve_q), 0);
    chk("idle_state", 32'(dut.state_q == ARB_CPU_PRI), 1);

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cm, tbl[i].cd,
            tbl[i].xr, tbl[i].xw, tbl[i].xa, tbl[i].xm, tbl[i].xd);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(tbl[i].gc));
      chk($sformatf("v%0d_ctx_gnt", i), 32'(ctx_gnt), 32'(tbl[i].gx));
      chk($sformatf("v%0d_ceb", i), 32'(mem_ceb), 32'(tbl[i].ceb));
      chk($sformatf("v%0d_web", i), 32'(mem_web), 32'(tbl[i].web));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_mask", i), 32'(mem_mask), 32'(tbl[i].mask));
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wd);
      chk($sformatf("v%0d_cpu_rv", i), 32'(cpu_rvalid), 32'(tbl[i].rvc));
      chk($sformatf("v%0d_ctx_rv", i), 32'(ctx_rvalid), 32'(tbl[i].rvx));
      if (tbl[i].rvc) chk($sformatf("v%0d_cpu_rd", i), cpu_rdata, tbl[i].rd);
      if (tbl[i].rvx) chk($sformatf("v%0d_ctx_rd", i), ctx_rdata, tbl[i].rd);
    end

    // Continuous conflict: CTX wins every fifth cycle
    begin
      logic pc, px, xw;
      pc = 0; px = 0;
      for (int k = 0; k < 11; k++) begin
        xw = (k % 5 == 4);
        @(posedge clk); #1;
        drive(1, 0, 10'h020, 4'hF, 0, 1, 0, 10'h030, 4'hF, 0);
        @(negedge clk);
        chk($sformatf("c%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(!xw));
        chk($sformatf("c%0d_ctx_gnt", k), 32'(ctx_gnt), 32'(xw));
        chk($sformatf("c%0d_addr", k), 32'(mem_addr),
            xw ? 32'h030 : 32'h020);
        chk($sformatf("c%0d_starve", k), 32'(dut.starve_q), 32'(k % 5));
        chk($sformatf("c%0d_cpu_rv", k), 32'(cpu_rvalid), 32'(pc));
        chk($sformatf("c%0d_ctx_rv", k), 32'(ctx_rvalid), 32'(px));
        if (pc) chk($sformatf("c%0d_cpu_rd", k), cpu_rdata, 32'hA5A50020);
        if (px) chk($sformatf("c%0d_ctx_rd", k), ctx_rdata, 32'hA5A50030);
        pc = !xw; px = xw;
      end
    end

    // Dropping ctx_req clears the starvation count
    @(posedge clk); #1;
    idle();
    begin
      logic [7:0] xr_pat;
      int exp_cnt [8];
      xr_pat = 8'b1111_1011;
      exp_cnt = '{0, 1, 2, 0, 1, 2, 3, 4};
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        drive(1, 1, 10'h040, 4'hF, 32'h1, xr_pat[k], 1, 10'h041,
              4'hF, 32'h2);
        @(negedge clk);
        chk($sformatf("d%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(k != 7));
        chk($sformatf("d%0d_ctx_gnt", k), 32'(ctx_gnt), 32'(k == 7));
        chk($sformatf("d%0d_starve", k), 32'(dut.starve_q),
            32'(exp_cnt[k]));
        chk($sformatf("d%0d_rv", k), 32'({cpu_rvalid, ctx_rvalid}), 0);
      end
    end

    // Reset right after a CPU read grant kills the rvalid
    @(posedge clk); #1;
    drive(1, 0, 10'h010, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r1_cpu_gnt", 32'(cpu_gnt), 1);
    @(posedge clk); #1;
    idle();
    resetn = 1'b0;
    #1;
    chk("r1_cpu_rv", 32'(cpu_rvalid), 0);
    chk("r1_ceb", 32'(mem_ceb), 1);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Read granted in the cycle reset asserts: no rvalid later
    drive(1, 0, 10'h011, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r2_cpu_gnt", 32'(cpu_gnt), 1);
    #2 resetn = 1'b0;
    #1;
    chk("r2_gnt_in_rst", 32'(cpu_gnt), 0);
    @(posedge clk); #1;
    chk("r2_cpu_rv", 32'(cpu_rvalid), 0);
    resetn = 1'b1;

    // First conflict after reset goes to CPU
    drive(1, 0, 10'h020, 4'hF, 0, 1, 0, 10'h030, 4'hF, 0);
    @(negedge clk);
    chk("r3_cpu_gnt", 32'(cpu_gnt), 1);
    chk("r3_ctx_gnt", 32'(ctx_gnt), 0);
    chk("r3_state", 32'(dut.state_q == ARB_CPU_PRI), 1);
    chk("r3_starve", 32'(dut.starve_q), 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("r3_cpu_rv", 32'(cpu_rvalid), 1);
    chk("r3_cpu_rd", cpu_rdata, 32'hA5A50020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
